// File: rtl/pie_encoder.sv
// EPC Gen2 PIE forward-link encoder: delimiter, data-0, RTcal, optional TRcal, then PIE bit symbols.
// Optional build macro PIE_TRCAL_RUNTIME_EN adds a trcal_ticks port sampled at frame start.
module pie_encoder #(
    parameter int TARI_TICKS  = 8,
    parameter int PW_TICKS    = 4,
    parameter int DELIM_TICKS = 6,
    parameter int TRCAL_TICKS = 32,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 preamble,
    input  logic                 in_dat,
    input  logic                 in_vld,
    input  logic                 in_last,
`ifdef PIE_TRCAL_RUNTIME_EN
    input  logic [CNT_WIDTH-1:0] trcal_ticks,
`endif
    output logic                 in_rdy,
    output logic                 tx_env,
    output logic                 busy,
    output logic                 done,
    output logic                 underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_DATA0,
        S_RTCAL,
        S_TRCAL,
        S_BITS
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DELIM_M1 = CNT_WIDTH'(DELIM_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] TARI_M1  = CNT_WIDTH'(TARI_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] BIT1_M1  = CNT_WIDTH'(2 * TARI_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] RTCAL_M1 = CNT_WIDTH'(3 * TARI_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] TRCAL_M1 = CNT_WIDTH'(TRCAL_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] PW_C     = CNT_WIDTH'(PW_TICKS);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 preamble_q, preamble_d;
    logic                 last_q, last_d;
    logic                 tx_env_q, tx_env_d;
    logic                 busy_q, busy_d;
    logic                 in_rdy_q, in_rdy_d;
    logic                 done_q, done_d;
    logic                 underflow_q, underflow_d;
    logic                 need_bit;
    logic [CNT_WIDTH-1:0] trcal_m1;

`ifdef PIE_TRCAL_RUNTIME_EN
    logic [CNT_WIDTH-1:0] trcal_m1_q;

    // Lengths at or below the pulse width would leave no high phase, so clamp to PW+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trcal_m1_q <= TRCAL_M1;
        end else if (state_q == S_IDLE && start) begin
            trcal_m1_q <= (trcal_ticks <= PW_C) ? PW_C : trcal_ticks - 1'b1;
        end
    end

    assign trcal_m1 = trcal_m1_q;
`else
    assign trcal_m1 = TRCAL_M1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            preamble_q  <= 1'b0;
            last_q      <= 1'b0;
            tx_env_q    <= 1'b1;
            busy_q      <= 1'b0;
            in_rdy_q    <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            preamble_q  <= preamble_d;
            last_q      <= last_d;
            tx_env_q    <= tx_env_d;
            busy_q      <= busy_d;
            in_rdy_q    <= in_rdy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        preamble_d  = preamble_q;
        last_d      = last_q;
        done_d      = 1'b0;
        underflow_d = 1'b0;
        need_bit    = 1'b0;

        if (state_q != S_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_DELIM;
                    cnt_d      = DELIM_M1;
                    preamble_d = preamble;
                    last_d     = 1'b0;
                end
            end
            S_DELIM: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA0;
                    cnt_d   = TARI_M1;
                end
            end
            S_DATA0: begin
                if (cnt_q == '0) begin
                    state_d = S_RTCAL;
                    cnt_d   = RTCAL_M1;
                end
            end
            S_RTCAL: begin
                if (cnt_q == '0) begin
                    if (preamble_q) begin
                        state_d = S_TRCAL;
                        cnt_d   = trcal_m1;
                    end else begin
                        need_bit = 1'b1;
                    end
                end
            end
            S_TRCAL: begin
                if (cnt_q == '0) begin
                    need_bit = 1'b1;
                end
            end
            S_BITS: begin
                if (cnt_q == '0) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        need_bit = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The cycle in_rdy is high is the last tick of a field; the next symbol must start now.
        if (need_bit) begin
            if (in_vld) begin
                state_d = S_BITS;
                cnt_d   = in_dat ? BIT1_M1 : TARI_M1;
                last_d  = in_last;
            end else begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                underflow_d = 1'b1;
            end
        end

        case (state_d)
            S_IDLE:  tx_env_d = 1'b1;
            S_DELIM: tx_env_d = 1'b0;
            default: tx_env_d = (cnt_d >= PW_C);
        endcase

        busy_d   = (state_d != S_IDLE);
        in_rdy_d = (cnt_d == '0) &&
                   ((state_d == S_RTCAL && !preamble_d) ||
                    (state_d == S_TRCAL) ||
                    (state_d == S_BITS && !last_d));
    end

    assign tx_env    = tx_env_q;
    assign busy      = busy_q;
    assign in_rdy    = in_rdy_q;
    assign done      = done_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pie_encoder.sv
// Directed bench for pie_encoder: a per-cycle envelope scoreboard is queued at frame start
// and popped each cycle; also exercises underflow, async reset mid-frame and back-to-back frames.
module tb_pie_encoder;

    localparam int TARI = 8;
    localparam int PW   = 4;

    logic clk;
    logic rst;
    logic start;
    logic preamble;
    logic inDat;
    logic inVld;
    logic inLast;
    logic inRdy;
    logic txEnv;
    logic busy;
    logic done;
    logic underflow;
`ifdef PIE_TRCAL_RUNTIME_EN
    logic [7:0] trcalTicks;
`endif

    int compared   = 0;
    int mismatched = 0;
    int trLen      = 32;

    // Scoreboard entry per cycle: {tx_env, in_rdy, busy, done}
    logic [3:0] expQ[$];
    bit         bitsQ[$];

    pie_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .preamble (preamble),
        .in_dat   (inDat),
        .in_vld   (inVld),
        .in_last  (inLast),
`ifdef PIE_TRCAL_RUNTIME_EN
        .trcal_ticks (trcalTicks),
`endif
        .in_rdy   (inRdy),
        .tx_env   (txEnv),
        .busy     (busy),
        .done     (done),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed {tx,rdy,busy,done,uf}=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pushSymbol(input int len, input bit rdyAtEnd);
        for (int i = 0; i < len; i++) begin
            expQ.push_back({(i < len - PW) ? 1'b1 : 1'b0,
                            (rdyAtEnd && i == len - 1) ? 1'b1 : 1'b0,
                            1'b1, 1'b0});
        end
    endtask

    task automatic buildExpected(input bit pre, input bit fullFrame);
        expQ.delete();
        for (int i = 0; i < 6; i++) expQ.push_back(4'b0010);
        pushSymbol(TARI, 1'b0);
        pushSymbol(3 * TARI, !pre);
        if (pre) pushSymbol(trLen, 1'b1);
        if (fullFrame) begin
            for (int k = 0; k < bitsQ.size(); k++) begin
                pushSymbol(bitsQ[k] ? 2 * TARI : TARI, k != bitsQ.size() - 1);
            end
        end
    endtask

    task automatic applyStimulus(input bit pre);
        inVld    = 1'b1;
        inDat    = bitsQ[0];
        inLast   = (bitsQ.size() == 1);
        start    = 1'b1;
        preamble = pre;
        @(posedge clk);
        #1;
        start    = 1'b0;
        preamble = 1'b0;
    endtask

    task automatic runFrame(input string tag, input int expEnd, input int expRdy, input logic vld,
                            input logic [4:0] endVec, input int startAt, input int resetAt);
        int idx      = 0;
        int cyc      = 0;
        int rdyCount = 0;
        bit rdySeen  = 1'b0;
        bit aborted  = 1'b0;
        logic [3:0] e;
        inVld = vld;
        while (expQ.size() > 0 && !aborted) begin
            e = expQ.pop_front();
            checkOutput(tag, {txEnv, inRdy, busy, done, underflow}, {e, 1'b0});
            if (inRdy) rdyCount++;
            if (cyc == resetAt) begin
                #2 rst = 1'b1;
                #1 checkOutput("asyncReset", {txEnv, inRdy, busy, done, underflow}, 5'b10000);
                expQ.delete();
                aborted = 1'b1;
                #2 rst = 1'b0;
            end else begin
                if (cyc == startAt) start = 1'b1;
                rdySeen = inRdy;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (rdySeen && idx < bitsQ.size() - 1) begin
                    idx++;
                    inDat  = bitsQ[idx];
                    inLast = (idx == bitsQ.size() - 1);
                end
                cyc++;
            end
        end
        if (!aborted) begin
            checkOutput({tag, "End"}, {txEnv, inRdy, busy, done, underflow}, endVec);
            checkCount({tag, "EndCycle"}, cyc, expEnd);
            checkCount({tag, "RdyCount"}, rdyCount, expRdy);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        preamble = 1'b0;
        inDat    = 1'b0;
        inVld    = 1'b0;
        inLast   = 1'b0;
`ifdef PIE_TRCAL_RUNTIME_EN
        trcalTicks = 8'd32;
`endif
        #3 checkOutput("reset", {txEnv, inRdy, busy, done, underflow}, 5'b10000);
        #20 rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("idle", {txEnv, inRdy, busy, done, underflow}, 5'b10000);

        // Frame-sync, bits 1,0
        bitsQ = '{1'b1, 1'b0};
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0);
        runFrame("fsync", 62, 2, 1'b1, 5'b10010, -1, -1);
        @(posedge clk);
        #1 checkOutput("fsyncIdle", {txEnv, inRdy, busy, done, underflow}, 5'b10000);

        // Preamble, same bits: TRcal inserted
        buildExpected(1'b1, 1'b1);
        applyStimulus(1'b1);
        runFrame("pre", 94, 2, 1'b1, 5'b10010, -1, -1);
        @(posedge clk);
        #1;

        // Underflow at first in_rdy
        bitsQ = '{1'b1};
        buildExpected(1'b0, 1'b0);
        applyStimulus(1'b0);
        runFrame("underflow", 38, 1, 1'b0, 5'b10001, -1, -1);
        @(posedge clk);
        #1 checkOutput("ufClear", {txEnv, inRdy, busy, done, underflow}, 5'b10000);

        // Start ignored while busy, then async reset mid-BITS
        bitsQ = '{1'b1, 1'b1, 1'b1, 1'b0};
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0);
        runFrame("abort", 0, 0, 1'b1, 5'b10010, 10, 50);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 checkOutput("postReset", {txEnv, inRdy, busy, done, underflow}, 5'b10000);
        end

        // Back-to-back: second start presented during the done cycle
        bitsQ = '{1'b0, 1'b1};
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0);
        runFrame("b2bA", 62, 2, 1'b1, 5'b10010, -1, -1);
        bitsQ = '{1'b1};
        buildExpected(1'b1, 1'b1);
        applyStimulus(1'b1);
        runFrame("b2bB", 86, 1, 1'b1, 5'b10010, -1, -1);
        @(posedge clk);
        #1;

`ifdef PIE_TRCAL_RUNTIME_EN
        trcalTicks = 8'd48;
        trLen      = 48;
        bitsQ      = '{1'b0};
        buildExpected(1'b1, 1'b1);
        applyStimulus(1'b1);
        runFrame("trcal48", 94, 1, 1'b1, 5'b10010, -1, -1);
        @(posedge clk);
        #1;
        trcalTicks = 8'd2;
        trLen      = PW + 1;
        buildExpected(1'b1, 1'b1);
        applyStimulus(1'b1);
        runFrame("trcalClamp", 51, 1, 1'b1, 5'b10010, -1, -1);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
